// File: rtl/key_expansion.sv
// AES-128 key schedule: expands one cipher key into 11 stored round keys, readable by index.
// Latency: start at edge k writes rk[i] at edge k+i; done pulses in the cycle after edge k+11.
// Backpressure: none; start is ignored while busy, and round_key is a combinational read.
module key_expansion #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [3:0]   rk_index,
    output logic [127:0] round_key,
    output logic         busy,
    output logic         done,
    output logic         keys_valid
);

    typedef enum logic [1:0] {IDLE, EXPAND, FINISH} state_t;

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t       state;
    state_t       state_nxt;
    logic [127:0] rk [0:NR];
    logic [127:0] work_key;      // most recently produced round key, source for the next one
    logic [7:0]   rcon;
    logic [3:0]   round_cnt;     // index of the round key written next; NR+1 once all are stored
    logic [31:0]  rot_word;
    logic [31:0]  temp;
    logic [31:0]  w0_nxt, w1_nxt, w2_nxt, w3_nxt;
    logic [127:0] key_nxt;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; EXPAND spends one extra cycle at round_cnt == NR+1 before FINISH
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = EXPAND;
            EXPAND:  if (round_cnt == 4'(NR + 1)) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy = (state != IDLE);
        done = (state == FINISH);
    end

    // One key-schedule step: RotWord, SubWord via four S-box lookups, rcon, then the xor chain
    always_comb begin
        rot_word = {work_key[23:0], work_key[31:24]};
        temp     = {SBOX[rot_word[31:24]], SBOX[rot_word[23:16]],
                    SBOX[rot_word[15:8]],  SBOX[rot_word[7:0]]} ^ {rcon, 24'h0};
        w0_nxt   = work_key[127:96] ^ temp;
        w1_nxt   = work_key[95:64]  ^ w0_nxt;
        w2_nxt   = work_key[63:32]  ^ w1_nxt;
        w3_nxt   = work_key[31:0]   ^ w2_nxt;
        key_nxt  = {w0_nxt, w1_nxt, w2_nxt, w3_nxt};
    end

    // Key storage, round counter, rcon and the keys_valid level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i <= NR; i++) rk[i] <= '0;
            work_key   <= '0;
            rcon       <= 8'h01;
            round_cnt  <= '0;
            keys_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rk[0]      <= key;
                        work_key   <= key;
                        rcon       <= 8'h01;
                        round_cnt  <= 4'd1;
                        keys_valid <= 1'b0;
                    end
                end
                EXPAND: begin
                    if (round_cnt <= 4'(NR)) begin
                        for (int i = 1; i <= NR; i++) begin
                            if (round_cnt == 4'(i)) rk[i] <= key_nxt;
                        end
                        work_key  <= key_nxt;
                        rcon      <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
                        round_cnt <= round_cnt + 4'd1;
                    end else begin
                        keys_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Round-key read port; indices beyond NR return zero
    always_comb begin
        round_key = '0;
        for (int i = 0; i <= NR; i++) begin
            if (rk_index == 4'(i)) round_key = rk[i];
        end
    end

endmodule

// File: tb/tb_key_expansion.sv
// Bench for key_expansion: directed FIPS-197 vectors, restart/reset corner cases, random keys.
// Reference: S-box derived from GF(2^8) inversion + affine map, schedule from the word recurrence.
// Inputs are driven and outputs sampled on the falling edge, away from the active edge.
module tb_key_expansion;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [127:0] key;
    logic [3:0]   rk_index;
    logic [127:0] round_key;
    logic         busy;
    logic         done;
    logic         keys_valid;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] sb [256];

    key_expansion #(.NR(10)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .key        (key),
        .rk_index   (rk_index),
        .round_key  (round_key),
        .busy       (busy),
        .done       (done),
        .keys_valid (keys_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(logic [7:0] x, int n);
        return 8'((x << n) | (x >> (8 - n)));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            if (a != 0) begin
                for (int c = 1; c < 256; c++) begin
                    if (gmul(8'(a), 8'(c)) == 8'h01) inv = 8'(c);
                end
            end
            sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_rk(logic [127:0] k, int r);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        if (r > 10) return 128'h0;
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic read_rk(input int idx, output logic [127:0] v);
        rk_index = 4'(idx);
        #1;
        v = round_key;
    endtask

    // Pulse start for one cycle; returns half a cycle after the edge that samples it
    task automatic start_expand(logic [127:0] k);
        @(negedge clk);
        key   = k;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = -1;
        for (int n = 1; n <= 30; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic check_all(logic [127:0] k, string tag);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) begin
            read_rk(i, v);
            chk($sformatf("%s rk%0d", tag, i), v, model_rk(k, i));
        end
    endtask

    task automatic full_run(logic [127:0] k, string tag);
        int lat;
        start_expand(k);
        chk({tag, " busy_after_start"}, 128'(busy), 128'd1);
        chk({tag, " kv_cleared"}, 128'(keys_valid), 128'd0);
        wait_done(lat);
        chk({tag, " done_latency"}, 128'(lat), 128'd11);
        chk({tag, " kv_in_finish"}, 128'(keys_valid), 128'd1);
        chk({tag, " busy_in_finish"}, 128'(busy), 128'd1);
        @(negedge clk);
        chk({tag, " done_one_cycle"}, 128'(done), 128'd0);
        chk({tag, " busy_idle"}, 128'(busy), 128'd0);
        chk({tag, " kv_held"}, 128'(keys_valid), 128'd1);
        check_all(k, tag);
    endtask

    initial begin
        logic [127:0] v;
        logic [127:0] ka, kb;
        int cnt_done, cnt_busy;

        build_sbox();
        reset = 1'b1; start = 1'b0; key = '0; rk_index = '0;

        // Reset state, both while held and after release
        repeat (2) @(negedge clk);
        chk("rst busy", 128'(busy), 128'd0);
        chk("rst done", 128'(done), 128'd0);
        chk("rst kv", 128'(keys_valid), 128'd0);
        read_rk(0, v);  chk("rst rk0", v, 128'h0);
        read_rk(10, v); chk("rst rk10", v, 128'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst busy", 128'(busy), 128'd0);
        chk("post_rst kv", 128'(keys_valid), 128'd0);

        // FIPS-197 and well-known vectors
        full_run(128'h000102030405060708090a0b0c0d0e0f, "v1");
        read_rk(0, v);  chk("v1 rk0 const", v, 128'h000102030405060708090a0b0c0d0e0f);
        read_rk(10, v); chk("v1 rk10 const", v, 128'h13111d7fe3944a17f307a78b4d2b30c5);

        full_run(128'h2b7e151628aed2a6abf7158809cf4f3c, "v2");
        read_rk(1, v);  chk("v2 rk1 const", v, 128'ha0fafe1788542cb123a339392a6c7605);
        read_rk(10, v); chk("v2 rk10 const", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        full_run(128'h5468617473206D79204B756E67204675, "v3");
        read_rk(1, v);  chk("v3 rk1 const", v, 128'he232fcf191129188b159e4e6d679a293);
        read_rk(10, v); chk("v3 rk10 const", v, 128'h28fddef86da4244accc0a4fe3b316f26);

        full_run(128'h0, "v0");
        read_rk(1, v);  chk("v0 rk1 const", v, 128'h62636363626363636263636362636363);
        read_rk(12, v); chk("v0 rk12 zero", v, 128'h0);

        // Second start during expansion is ignored
        ka = {$urandom, $urandom, $urandom, $urandom};
        kb = ~ka;
        start_expand(ka);
        repeat (3) @(negedge clk);
        key = kb; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt_done = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (done === 1'b1) cnt_done++;
        end
        chk("restart done_count", 128'(cnt_done), 128'd1);
        chk("restart kv", 128'(keys_valid), 128'd1);
        check_all(ka, "restart");

        // Reset mid-expansion aborts; start during reset is ignored
        ka = {$urandom, $urandom, $urandom, $urandom};
        rk_index = 4'd0;
        start_expand(ka);
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort busy", 128'(busy), 128'd0);
        chk("abort kv", 128'(keys_valid), 128'd0);
        chk("abort done", 128'(done), 128'd0);
        chk("abort rk0", round_key, 128'h0);
        @(negedge clk);
        key = ~ka; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        cnt_done = 0; cnt_busy = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (done === 1'b1) cnt_done++;
            if (busy === 1'b1) cnt_busy++;
        end
        chk("abort no_done", 128'(cnt_done), 128'd0);
        chk("abort start_in_reset_ignored", 128'(cnt_busy), 128'd0);
        chk("abort kv_after", 128'(keys_valid), 128'd0);
        full_run(kb, "after_abort");

        // Random keys
        for (int r = 0; r < 4; r++) begin
            ka = {$urandom, $urandom, $urandom, $urandom};
            full_run(ka, $sformatf("rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
